// File: rtl/rf_pkg.sv
// Shared widths and types for the register bank and its pending-write scoreboard.
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREGS  = 32;

    typedef logic [RF_ADDR_W-1:0] rf_idx_t;
    typedef logic [RF_DATA_W-1:0] rf_word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue handshake,
// cleared on writeback. Register 0 and indices >= NREGS are never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic              iss_ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa
);
    logic busy_reg [1:NREGS-1];
    logic busy_iss;
    logic iss_fire;

    // Index-compare muxes keep out-of-range addresses reading as not busy.
    always_comb begin
        busy1    = 1'b0;
        busy2    = 1'b0;
        busy_iss = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (int'(ra1) == i)    busy1    = busy_reg[i];
            if (int'(ra2) == i)    busy2    = busy_reg[i];
            if (int'(iss_wa) == i) busy_iss = busy_reg[i];
        end
    end

    // A writeback in the same cycle frees the slot for the next producer.
    assign iss_ready = !busy_iss || (we && (wa == iss_wa));
    assign iss_fire  = iss_valid && iss_ready;

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
        // Set has priority over clear when issue and writeback hit the same register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                busy_reg[gi] <= 1'b0;
            else if (iss_fire && (int'(iss_wa) == gi))
                busy_reg[gi] <= 1'b1;
            else if (we && (int'(wa) == gi))
                busy_reg[gi] <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register bank with pending-write scoreboard; register 0 reads zero.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic              iss_ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] regs_reg [1:NREGS-1];
    logic [DATA_W-1:0] rd1_raw;
    logic [DATA_W-1:0] rd2_raw;
    logic              sb_busy1;
    logic              sb_busy2;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (sb_busy1),
        .busy2     (sb_busy2),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .iss_ready (iss_ready),
        .we        (we),
        .wa        (wa)
    );

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                regs_reg[gi] <= '0;
            else if (we && (int'(wa) == gi))
                regs_reg[gi] <= wd;
        end
    end

    always_comb begin
        rd1_raw = '0;
        rd2_raw = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (int'(ra1) == i) rd1_raw = regs_reg[i];
            if (int'(ra2) == i) rd2_raw = regs_reg[i];
        end
    end

`ifdef RF_BYPASS_EN
    logic wr_valid;
    logic hit1;
    logic hit2;

    // Only writes that will actually land in the array are forwarded.
    assign wr_valid = we && (wa != '0) && (int'(wa) < NREGS);
    assign hit1     = wr_valid && (wa == ra1);
    assign hit2     = wr_valid && (wa == ra2);

    assign rd1      = hit1 ? wd : rd1_raw;
    assign rd2      = hit2 ? wd : rd2_raw;
    assign rd1_busy = hit1 ? 1'b0 : sb_busy1;
    assign rd2_busy = hit2 ? 1'b0 : sb_busy2;
`else
    assign rd1      = rd1_raw;
    assign rd2      = rd2_raw;
    assign rd1_busy = sb_busy1;
    assign rd2_busy = sb_busy2;
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard; a 16-register instance checks out-of-range indices.
module tb_regfile_scoreboard;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          use_b;
        logic [66:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, iss_wa, wa;
    logic [31:0] wd;
    logic        iss_valid, we;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_b1, a_b2, a_rdy, b_b1, b_b2, b_rdy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2),
        .rd1(a_rd1), .rd2(a_rd2), .rd1_busy(a_b1), .rd2_busy(a_b2),
        .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_ready(a_rdy),
        .we(we), .wa(wa), .wd(wd)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREGS(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2),
        .rd1(b_rd1), .rd2(b_rd2), .rd1_busy(b_b1), .rd2_busy(b_b2),
        .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_ready(b_rdy),
        .we(we), .wa(wa), .wd(wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drains every expectation queued for this cycle on the falling edge.
    always @(negedge clk) begin
        logic [66:0] act;
        exp_t        e;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = e.use_b ? {b_rd1, b_rd2, b_b1, b_b2, b_rdy}
                          : {a_rd1, a_rd2, a_b1, a_b2, a_rdy};
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got rd1=%h rd2=%h b1=%b b2=%b rdy=%b, want rd1=%h rd2=%h b1=%b b2=%b rdy=%b",
                         e.name, act[66:35], act[34:3], act[2], act[1], act[0],
                         e.val[66:35], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end else begin
                $display("txn %s: rd1=%h rd2=%h b1=%b b2=%b rdy=%b ok",
                         e.name, act[66:35], act[34:3], act[2], act[1], act[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic [4:0] iw,
                         input logic w, input logic [4:0] wadr, input logic [31:0] wdat);
        rst_n = r; ra1 = a1; ra2 = a2;
        iss_valid = iv; iss_wa = iw;
        we = w; wa = wadr; wd = wdat;
    endtask

    task automatic expect_o(input string nm, input bit use_b,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input logic eb1, input logic eb2, input logic er);
        exp_t e;
        e.name  = nm;
        e.use_b = use_b;
        e.val   = {e1, e2, eb1, eb2, er};
        exp_q.push_back(e);
    endtask

    initial begin
        drive(1'b0, 5'd3, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        expect_o("reset_held", 0, 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd3, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        expect_o("after_reset", 0, 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        expect_o("write5_same_cycle", 0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1);
        expect_o("read5_write0", 0, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        expect_o("reg0_still_zero", 0, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        expect_o("issue7", 0, 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        expect_o("reissue7_stall", 0, 32'h0, 32'h0, 1, 0, 0);
        cyc();

        drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'hAAAA5555);
        expect_o("reissue7_with_wb", 0, BYP ? 32'hAAAA5555 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 0, 1);
        cyc();

        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 5'd0, 32'h0);
        expect_o("reg7_rebusy", 0, 32'hAAAA5555, 32'h0, 1, 0, 0);
        cyc();

        drive(1'b1, 5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        expect_o("issue9", 0, 32'hAAAA5555, 32'h0, 1, 0, 1);
        cyc();

        drive(1'b1, 5'd7, 5'd9, 1'b0, 5'd9, 1'b1, 5'd9, 32'h12345678);
        expect_o("wb9_same_cycle", 0, 32'hAAAA5555, BYP ? 32'h12345678 : 32'h0, 1, BYP ? 1'b0 : 1'b1, 1);
        cyc();

        drive(1'b1, 5'd7, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        expect_o("reg9_released", 0, 32'hAAAA5555, 32'h12345678, 1, 0, 1);
        cyc();

        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h00000033);
        expect_o("unreserved_wr3", 0, BYP ? 32'h00000033 : 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        expect_o("reg3_not_busy", 0, 32'h00000033, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd7, 5'd4, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
        cyc();
        drive(1'b1, 5'd7, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
        cyc();
        drive(1'b1, 5'd7, 5'd4, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0);
        cyc();

        drive(1'b1, 5'd7, 5'd4, 1'b0, 5'd6, 1'b0, 5'd0, 32'h0);
        expect_o("busy_2_4_6", 0, 32'hAAAA5555, 32'h0, 1, 1, 0);
        cyc();

        drive(1'b0, 5'd7, 5'd4, 1'b0, 5'd6, 1'b0, 5'd0, 32'h0);
        expect_o("async_reset_mid", 0, 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd9, 5'd5, 1'b0, 5'd2, 1'b0, 5'd0, 32'h0);
        expect_o("post_reset_zero", 0, 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd20, 5'd0, 1'b1, 5'd20, 1'b1, 5'd20, 32'h0000FFFF);
        expect_o("n16_idx20_wr", 1, 32'h0, 32'h0, 0, 0, 1);
        cyc();

        drive(1'b1, 5'd20, 5'd0, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0);
        expect_o("n16_idx20_never_busy", 1, 32'h0, 32'h0, 0, 0, 1);
        expect_o("n32_idx20_busy", 0, 32'h0000FFFF, 32'h0, 1, 0, 0);
        cyc();

        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
